// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared defaults, counter width and FSM state encoding for dmem_responder
package dmem_pkg;

    localparam int DMEM_ADDR_W      = 10;
    localparam int DMEM_DATA_W      = 32;
    localparam int DMEM_WAIT_CYCLES = 2;
    localparam int DMEM_CNT_W       = 4;

    typedef logic [1:0] dmem_state_t;

    localparam dmem_state_t ST_IDLE   = 2'd0;
    localparam dmem_state_t ST_WAIT   = 2'd1;
    localparam dmem_state_t ST_ACCESS = 2'd2;
    localparam dmem_state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous RAM, one read or one write per cycle
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              CLK,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // Contents are never reset; they survive RST by design.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write or registered read; rdata holds its value until the next read.
    always_ff @(posedge CLK) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder; DMEM_WRITE_ACK_EN enables store acks
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_is_wr
);

    // Counter preload; the WAIT state counts this value down to zero inclusive.
    localparam logic [DMEM_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? DMEM_CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_t             state;
    dmem_state_t             state_nxt;
    logic [DMEM_CNT_W-1:0]   cnt;
    logic                    accept;
    logic                    ram_en;
    logic                    store_ack;
    logic                    we_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       ram_rdata;

`ifdef DMEM_WRITE_ACK_EN
    assign store_ack = 1'b1;
    assign rsp_is_wr = rsp_valid && we_q;
`else
    assign store_ack = 1'b0;
    assign rsp_is_wr = 1'b0;
`endif

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    // A reset landing on the access cycle must not disturb memory.
    assign ram_en    = (state == ST_ACCESS) && !RST;
    assign rsp_valid = (state == ST_RESP);
    // RAM output is stable through RESP because the array is only enabled in ACCESS.
    assign rsp_rdata = (rsp_valid && !we_q) ? ram_rdata : '0;

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   if (cnt == '0) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = (we_q && !store_ack) ? ST_IDLE : ST_RESP;
            ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register and wait-state counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= WAIT_LOAD;
            end else if ((state == ST_WAIT) && (cnt != '0)) begin
                cnt <= cnt - DMEM_CNT_W'(1);
            end
        end
    end

    // Request capture; inputs are ignored until the next acceptance.
    always_ff @(posedge CLK) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .CLK   (CLK),
        .en    (ram_en),
        .we    (we_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule
